// File: rtl/alu_cmd_framer_if.sv
// Bundles the UART byte streams, adder operand/result bus and framer status lines.
// slave is the framer side; master is the surrounding UART/adder/test side.
interface alu_cmd_framer_if #(
    parameter int unsigned N = 16
) ();

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         frame_err;

    modport slave (
        input  rx_data, rx_valid, alu_result, alu_flags, tx_ready,
        output op_a, op_b, tx_data, tx_valid, busy, frame_err
    );

    modport master (
        output rx_data, rx_valid, alu_result, alu_flags, tx_ready,
        input  op_a, op_b, tx_data, tx_valid, busy, frame_err
    );

endinterface

// File: rtl/alu_cmd_framer.sv
// Byte framer between UART RX/TX and the N-bit adder: header hunt, operand assembly, response.
// Define ALU_FRAME_CKSUM_EN to add an XOR checksum byte to both request and response.
module alu_cmd_framer #(
    parameter int unsigned N       = 16,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 100000
) (
    input logic             clk,
    input logic             rst_n,
    alu_cmd_framer_if.slave bus
);

    localparam int unsigned OpBytes = N / 8;
`ifdef ALU_FRAME_CKSUM_EN
    localparam int unsigned ReqBytes = 2 * OpBytes + 1;
    localparam int unsigned RspBytes = OpBytes + 2;
    localparam int unsigned ShW      = 2 * N;
`else
    localparam int unsigned ReqBytes = 2 * OpBytes;
    localparam int unsigned RspBytes = OpBytes + 1;
    localparam int unsigned ShW      = 2 * N - 8;
`endif
    localparam int unsigned CntW = $clog2(ReqBytes + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned RspW = RspBytes * 8;

    localparam logic [CntW-1:0] LastReq = CntW'(ReqBytes - 1);
    localparam logic [CntW-1:0] LastRsp = CntW'(RspBytes - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRxOps, StExec, StTx} state_e;

    state_e          state_q;
    logic [ShW-1:0]  shift_q;
    logic [CntW-1:0] byte_cnt_q;
    logic [TmoW-1:0] tmo_q;
    logic [N-1:0]    op_a_q;
    logic [N-1:0]    op_b_q;
    logic [RspW-1:0] rsp_q;
    logic [RspW-1:0] rsp_nxt;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            frame_err_q;

`ifdef ALU_FRAME_CKSUM_EN
    logic [7:0] cks_q;
    logic [7:0] rsp_cks;

    always_comb begin
        rsp_cks = {4'b0000, bus.alu_flags};
        for (int i = 0; i < int'(OpBytes); i++) begin
            rsp_cks = rsp_cks ^ bus.alu_result[i*8 +: 8];
        end
        rsp_nxt = {bus.alu_result, 4'b0000, bus.alu_flags, rsp_cks};
    end
`else
    // Shadow holds all but the final operand byte; the final byte is taken straight from rx_data.
    logic [2*N-1:0] req_w;

    assign req_w   = {shift_q, bus.rx_data};
    assign rsp_nxt = {bus.alu_result, 4'b0000, bus.alu_flags};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef ALU_FRAME_CKSUM_EN
            cks_q       <= 8'h00;
`endif
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_valid && bus.rx_data == HEADER) begin
                        state_q    <= StRxOps;
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
`ifdef ALU_FRAME_CKSUM_EN
                        cks_q      <= 8'h00;
`endif
                    end
                end

                StRxOps: begin
                    if (bus.rx_valid) begin
                        tmo_q <= '0;
                        if (byte_cnt_q == LastReq) begin
                            byte_cnt_q <= '0;
`ifdef ALU_FRAME_CKSUM_EN
                            if (bus.rx_data == cks_q) begin
                                op_a_q  <= shift_q[2*N-1:N];
                                op_b_q  <= shift_q[N-1:0];
                                state_q <= StExec;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= StIdle;
                            end
`else
                            op_a_q  <= req_w[2*N-1:N];
                            op_b_q  <= req_w[N-1:0];
                            state_q <= StExec;
`endif
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CntW'(1);
`ifdef ALU_FRAME_CKSUM_EN
                            shift_q    <= {shift_q[ShW-9:0], bus.rx_data};
                            cks_q      <= cks_q ^ bus.rx_data;
`else
                            shift_q    <= req_w[ShW-1:0];
`endif
                        end
                    end else if (tmo_q == TmoLast) begin
                        // Partial frame is abandoned; operands keep their last good values.
                        frame_err_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end

                StExec: begin
                    if (bus.rx_valid) begin
                        frame_err_q <= 1'b1;
                    end
                    tx_data_q  <= rsp_nxt[RspW-1 -: 8];
                    rsp_q      <= rsp_nxt << 8;
                    tx_valid_q <= 1'b1;
                    byte_cnt_q <= '0;
                    state_q    <= StTx;
                end

                StTx: begin
                    if (bus.rx_valid) begin
                        frame_err_q <= 1'b1;
                    end
                    if (tx_valid_q && bus.tx_ready) begin
                        if (byte_cnt_q == LastRsp) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            tx_data_q  <= rsp_q[RspW-1 -: 8];
                            rsp_q      <= rsp_q << 8;
                            byte_cnt_q <= byte_cnt_q + CntW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_framer.sv
// Randomised + directed bench for alu_cmd_framer against a queue-based frame model.
// Honours ALU_FRAME_CKSUM_EN the same way as the design.
module tb_alu_cmd_framer;

    localparam int unsigned N   = 16;
    localparam int unsigned OB  = N / 8;
    localparam int unsigned TMO = 40;
`ifdef ALU_FRAME_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_framer_if #(.N(N)) bus ();

    alu_cmd_framer #(.N(N), .HEADER(8'hA5), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in adder: combinational sum and {V,N,Z,P} flags.
    logic [N-1:0] sum_w;
    assign sum_w = bus.op_a + bus.op_b;
    assign bus.alu_result = sum_w;
    assign bus.alu_flags  = {(bus.op_a[N-1] == bus.op_b[N-1]) && (sum_w[N-1] != bus.op_a[N-1]),
                             sum_w[N-1], sum_w == '0, ~^sum_w};

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int ready_mode = 1;
    logic [7:0] log_q[$];

    // Reference model state
    int           ph;
    int           quiet;
    logic [7:0]   req[$];
    logic [7:0]   rsp[$];
    logic [N-1:0] m_a, m_b;
    logic         m_err, m_txv;
    logic [7:0]   m_txd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_rsp();
        int sa, sb, s;
        logic [N-1:0] r;
        logic [7:0] x;
        logic v, z, p;
        sa = int'($signed(m_a));
        sb = int'($signed(m_b));
        s  = sa + sb;
        r  = m_a + m_b;
        v  = (s > (2 ** (N - 1)) - 1) || (s < -(2 ** (N - 1)));
        z  = (s % (2 ** N)) == 0;
        p  = ($countones(r) % 2) == 0;
        rsp.delete();
        x = 8'h00;
        for (int i = OB - 1; i >= 0; i--) begin
            rsp.push_back(r[i*8 +: 8]);
            x = x ^ r[i*8 +: 8];
        end
        rsp.push_back({4'b0000, v, r[N-1], z, p});
        x = x ^ {4'b0000, v, r[N-1], z, p};
        if (CK == 1) rsp.push_back(x);
    endfunction

    function automatic void finish_request();
        logic [N-1:0] a, b;
        logic [7:0] x;
        a = '0;
        b = '0;
        x = 8'h00;
        for (int i = 0; i < int'(OB); i++) begin
            a = (a << 8) | N'(req[i]);
            b = (b << 8) | N'(req[OB + i]);
            x = x ^ req[i] ^ req[OB + i];
        end
        if (CK == 1 && req[2*OB] != x) begin
            m_err = 1'b1;
            ph = 0;
        end else begin
            m_a = a;
            m_b = b;
            ph = 2;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; quiet = 0; req.delete(); rsp.delete();
            m_a = '0; m_b = '0; m_err = 1'b0; m_txv = 1'b0; m_txd = 8'h00;
        end else begin
            m_err = 1'b0;
            case (ph)
                0: if (bus.rx_valid && bus.rx_data == 8'hA5) begin
                    ph = 1; quiet = 0; req.delete();
                end
                1: if (bus.rx_valid) begin
                    req.push_back(bus.rx_data);
                    quiet = 0;
                    if (req.size() == 2 * OB + CK) finish_request();
                end else begin
                    quiet++;
                    if (quiet == TMO) begin
                        m_err = 1'b1;
                        ph = 0;
                    end
                end
                2: begin
                    if (bus.rx_valid) m_err = 1'b1;
                    build_rsp();
                    m_txd = rsp.pop_front();
                    m_txv = 1'b1;
                    ph = 3;
                end
                default: begin
                    if (bus.rx_valid) m_err = 1'b1;
                    if (m_txv && bus.tx_ready) begin
                        if (rsp.size() == 0) begin
                            m_txv = 1'b0;
                            ph = 0;
                        end else begin
                            m_txd = rsp.pop_front();
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("op_a", 32'(bus.op_a), 32'(m_a));
        check("op_b", 32'(bus.op_b), 32'(m_b));
        check("busy", 32'(bus.busy), 32'(ph != 0));
        check("frame_err", 32'(bus.frame_err), 32'(m_err));
        check("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        if (m_txv || !rst_n) check("tx_data", 32'(bus.tx_data), 32'(m_txd));
        if (bus.frame_err) err_pulses++;
        if (rst_n && bus.tx_valid && bus.tx_ready) log_q.push_back(bus.tx_data);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.tx_ready = 1'b0;
            1: bus.tx_ready = 1'b1;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [7:0] bad, input int gap_max, input bit allow_long);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int gap;
        x = 8'h00;
        for (int i = OB - 1; i >= 0; i--) bytes.push_back(a[i*8 +: 8]);
        for (int i = OB - 1; i >= 0; i--) bytes.push_back(b[i*8 +: 8]);
        send(8'hA5);
        foreach (bytes[i]) begin
            gap = $urandom_range(0, gap_max);
            if (allow_long && $urandom_range(0, 29) == 0) gap = TMO + 3;
            tick(gap);
            send(bytes[i]);
            x = x ^ bytes[i];
        end
        if (CK == 1) send(x ^ bad);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((ph != 0 || bus.busy) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic expect_log(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        logic [7:0] exp_q[$];
        exp_q = '{b0, b1, b2};
        if (CK == 1) exp_q.push_back(b0 ^ b1 ^ b2);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < log_q.size()) check({name, "_byte"}, 32'(log_q[i]), 32'(exp_q[i]));
        end
        log_q.delete();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [N-1:0] ra, rb;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        tick(3);
        check("rst_op_a", 32'(bus.op_a), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Overflowing add, latency of first response byte
        log_q.delete();
        send_frame(16'h7FFF, 16'h0001, 8'h00, 0, 1'b0);
        check("lat_exec", 32'(bus.tx_valid), 32'h0);
        tick(1);
        check("lat_tx", 32'(bus.tx_valid), 32'h1);
        check("first_byte", 32'(bus.tx_data), 32'h80);
        wait_idle(50);
        expect_log("t1", 8'h80, 8'h00, 8'h0C);
        check("t1_op_a", 32'(bus.op_a), 32'h7FFF);
        check("t1_op_b", 32'(bus.op_b), 32'h0001);

        // Wrap to zero
        send_frame(16'h0001, 16'hFFFF, 8'h00, 0, 1'b0);
        wait_idle(50);
        expect_log("t2", 8'h00, 8'h00, 8'h03);
        check("t2_busy", 32'(bus.busy), 32'h0);

        // Garbage before header is silent
        base = err_pulses;
        send(8'h12);
        send(8'h34);
        tick(1);
        check("garbage_err", 32'(err_pulses - base), 32'h0);
        send_frame(16'h0002, 16'h0003, 8'h00, 0, 1'b0);
        wait_idle(50);
        expect_log("t3", 8'h00, 8'h05, 8'h01);

        // Timeout mid-frame
        base = err_pulses;
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        tick(TMO + 5);
        check("tmo_pulses", 32'(err_pulses - base), 32'h1);
        check("tmo_busy", 32'(bus.busy), 32'h0);
        check("tmo_op_a", 32'(bus.op_a), 32'h0002);
        send_frame(16'h0001, 16'h0001, 8'h00, 0, 1'b0);
        wait_idle(50);
        expect_log("t4", 8'h00, 8'h02, 8'h00);

        // Backpressure with a dropped rx byte
        ready_mode = 0;
        send_frame(16'h7FFF, 16'h0001, 8'h00, 0, 1'b0);
        tick(2);
        base = err_pulses;
        for (int i = 0; i < 10; i++) begin
            check("hold_data", 32'(bus.tx_data), 32'h80);
            check("hold_valid", 32'(bus.tx_valid), 32'h1);
            if (i == 4) send(8'h55);
            else tick(1);
        end
        check("drop_err", 32'(err_pulses - base), 32'h1);
        ready_mode = 1;
        wait_idle(50);
        expect_log("t5", 8'h80, 8'h00, 8'h0C);

        // Asynchronous reset during a stalled response
        ready_mode = 0;
        send_frame(16'h1234, 16'h1111, 8'h00, 0, 1'b0);
        tick(3);
        #2 rst_n = 1'b0;
        tick(2);
        check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
        check("mid_rst_op_a", 32'(bus.op_a), 32'h0);
        rst_n = 1'b1;
        ready_mode = 1;
        tick(5);
        check("post_rst_valid", 32'(bus.tx_valid), 32'h0);
        check("post_rst_log", 32'(log_q.size()), 32'h0);
        log_q.delete();

`ifdef ALU_FRAME_CKSUM_EN
        // Bad checksum leaves operands alone and sends nothing
        send_frame(16'h0005, 16'h0006, 8'h00, 0, 1'b0);
        wait_idle(50);
        log_q.delete();
        base = err_pulses;
        send_frame(16'h7FFF, 16'h0001, 8'h03, 0, 1'b0);
        tick(5);
        check("ck_err", 32'(err_pulses - base), 32'h1);
        check("ck_log", 32'(log_q.size()), 32'h0);
        check("ck_op_a", 32'(bus.op_a), 32'h0005);
`endif

        // Random frames, gaps, garbage, backpressure and drops
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] g;
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send(g);
                tick($urandom_range(0, 3));
            end
            ra = N'($urandom);
            rb = N'($urandom);
            send_frame(ra, rb, ($urandom_range(0, 7) == 0) ? 8'h10 : 8'h00, 3, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 6 && ph != 3; k++) tick(1);
                if (ph == 3) send(8'($urandom));
            end
            wait_idle(600);
            log_q.delete();
        end

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_framer.md
Name: alu_cmd_framer

Overview:
- Byte-level command framer between the UART receiver/transmitter and the 16-bit CLA adder datapath.
- Hunts for a header byte, then assembles two big-endian operands from the UART RX byte stream.
- Presents the operands to the adder as registered values and captures the combinational result and flags one cycle later.
- Serialises the result and flags back to the UART TX over a valid/ready handshake.

Parameters:
- N, 16, operand/result width; must be a multiple of 8, range 8..32; operand byte count OB = N/8.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 100000, maximum clk cycles allowed between consecutive request bytes inside a frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle, no backpressure.
- op_a  output  N  operand a to adder, registered.
- op_b  output  N  operand b to adder, registered.
- alu_result  input  N  adder result, combinational from op_a/op_b.
- alu_flags  input  4  adder flags {V,N,Z,P}.
- tx_data  output  8  response byte to UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts a byte when tx_valid && tx_ready.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse on timeout or dropped byte.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; op_a, op_b, tx_data = 0; tx_valid, busy, frame_err = 0; byte counter and timeout counter = 0.
- IDLE: rx_valid with rx_data==HEADER goes to RX_OPS with byte_cnt=0. Any other byte is discarded silently, with no frame_err.
- RX_OPS:
  - Each rx_valid shifts the byte into a 2*N shadow register, MSB first: a_hi..a_lo, then b_hi..b_lo. byte_cnt increments.
  - A byte equal to HEADER inside RX_OPS is data, not a resync.
  - Timeout counter clears on each accepted byte and increments otherwise.
  - Counter reaching TIMEOUT: pulse frame_err, discard partial frame, go to IDLE. op_a/op_b stay unchanged.
  - The 2*OB-th byte, accepted at cycle t: op_a/op_b load at the end of t; state becomes EXEC in t+1.
- EXEC (exactly 1 cycle):
  - Capture alu_result and alu_flags into the response register.
  - Load tx_data = result[N-1:N-8]; assert tx_valid from t+2. Go to TX.
- TX:
  - Response order: result bytes MSB first, then {4'b0, alu_flags}. Total OB+1 bytes.
  - tx_data and tx_valid stay stable while tx_valid && !tx_ready.
  - On handshake, advance to the next byte the following cycle. No gap cycle is required between bytes.
  - After the last byte handshakes, tx_valid=0 and state returns to IDLE.
- rx_valid during EXEC or TX: byte dropped, frame_err pulses. The dropped byte is not examined for HEADER.
- op_a/op_b hold their last values until the next complete frame.
- Reset asserted mid-frame or mid-TX: immediate return to reset values; no partial byte is emitted after release.
- Timeout is not applied in IDLE, EXEC or TX; TX waits indefinitely for tx_ready.

Optional Feature:
- Macro: ALU_FRAME_CKSUM_EN.
- When defined:
  - The request carries one extra byte after the operands: XOR of all operand bytes, header excluded.
  - On mismatch: pulse frame_err, do not update op_a/op_b, send no response, return to IDLE.
  - The response appends one extra byte: XOR of all preceding response bytes.
- When undefined: no checksum byte on either side; frame lengths are 1+2*OB in and OB+1 out.

Test Plan:
- Request A5 7F FF 00 01, tx_ready=1 -> op_a=0x7FFF, op_b=0x0001; response 80 00 0C (V=1,N=1,Z=0,P=0); tx_valid first high 2 cycles after the last byte.
- Request A5 00 01 FF FF -> response 00 00 03 (Z=1,P=1); busy low after the third handshake.
- Leading garbage 12 34 followed by A5 00 02 00 03 -> no frame_err for the garbage; response 00 05 01.
- Header, then 2 operand bytes, then silence for TIMEOUT+1 cycles -> single frame_err pulse; state IDLE; a following full frame A5 00 01 00 01 returns 00 02 00.
- tx_ready held low 10 cycles during the first response byte -> tx_data stable at 0x80 with tx_valid high. An rx byte arriving during this wait -> frame_err pulse; response unaffected.
- With ALU_FRAME_CKSUM_EN: A5 7F FF 00 01 81 -> response 80 00 0C 8C. Same frame with checksum 82 -> frame_err, no response, op_a/op_b unchanged.
